// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops, iterative shifts (1 bit/cycle)
// and shift-add multiply, behind an inicio/ocupado/pronto handshake.
//   state   | meaning
//   OCIOSO  | idle, waiting for an accepted start
//   CALCULA | operands captured, iterating until the result is ready
module ula_multiciclo #(
    parameter int BITS = 64,
    parameter int SHW  = $clog2(BITS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inicio,
    input  logic [3:0]      operacao,
    input  logic [BITS-1:0] dina,
    input  logic [BITS-1:0] dinb,
    input  logic [BITS-1:0] constante,
    input  logic            imediato,
    output logic            ocupado,
    output logic            pronto,
    output logic [BITS-1:0] dout,
    output logic            zero
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic {OCIOSO, CALCULA} estado_t;

    estado_t         r_estado;
    logic [BITS-1:0] r_a;
    logic [BITS-1:0] r_b;
    logic [BITS-1:0] r_acc;
    logic [3:0]      r_op;
    logic [SHW-1:0]  r_cnt;

    logic [BITS-1:0] w_b_sel;
    logic [BITS-1:0] w_res;
    logic [BITS-1:0] w_desl;
    logic [BITS-1:0] w_soma;
    logic [BITS-1:0] w_val;
    logic            w_iter;
    logic            w_fim;

    assign w_b_sel = imediato ? constante : dinb;

    always_comb begin
        w_res = '0;
        case (r_op)
            OP_ADD:  w_res = r_a + r_b;
            OP_SUB:  w_res = r_a - r_b;
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            OP_XOR:  w_res = r_a ^ r_b;
            OP_SLT:  w_res[0] = $signed(r_a) < $signed(r_b);
            OP_SLTU: w_res[0] = r_a < r_b;
            default: w_res = '0;
        endcase

        case (r_op)
            OP_SLL:  w_desl = r_a << 1;
            OP_SRL:  w_desl = r_a >> 1;
            OP_SRA:  w_desl = {r_a[BITS-1], r_a[BITS-1:1]};
            default: w_desl = r_a;
        endcase

        // r_a holds the left-shifted multiplicand, r_b the right-shifted multiplier
        w_soma = r_acc + (r_b[0] ? r_a : '0);
        w_iter = (r_op == OP_SLL) || (r_op == OP_SRL) || (r_op == OP_SRA) || (r_op == OP_MUL);
        w_fim  = !w_iter || (r_cnt == '0);

        if (r_op == OP_MUL)
            w_val = w_soma;
        else if (w_iter)
            w_val = r_a;
        else
            w_val = w_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= OCIOSO;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
            dout     <= '0;
            zero     <= 1'b1;
        end else begin
            pronto <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (inicio) begin
                        r_a      <= dina;
                        r_b      <= w_b_sel;
                        r_op     <= operacao;
                        r_acc    <= '0;
                        r_cnt    <= (operacao == OP_MUL) ? SHW'(BITS - 1) : w_b_sel[SHW-1:0];
                        ocupado  <= 1'b1;
                        r_estado <= CALCULA;
                    end
                end
                CALCULA: begin
                    if (w_fim) begin
                        dout     <= w_val;
                        zero     <= (w_val == '0);
                        pronto   <= 1'b1;
                        ocupado  <= 1'b0;
                        r_estado <= OCIOSO;
                    end else begin
                        r_cnt <= r_cnt - SHW'(1);
                        if (r_op == OP_MUL) begin
                            r_acc <= w_soma;
                            r_a   <= r_a << 1;
                            r_b   <= r_b >> 1;
                        end else begin
                            r_a <= w_desl;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo: a 64-bit instance checked against a behavioural
// model with latency tracking, plus an 8-bit instance exercising reset mid-operation.
module tb_ula_multiciclo;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst, inicio, imediato, ocupado, pronto, zero;
    logic [3:0]  operacao;
    logic [63:0] dina, dinb, constante, dout;

    logic        rst8, inicio8, imm8, ocupado8, pronto8, zero8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, k8, dout8;

    ula_multiciclo #(.BITS(64)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .operacao(operacao),
        .dina(dina), .dinb(dinb), .constante(constante), .imediato(imediato),
        .ocupado(ocupado), .pronto(pronto), .dout(dout), .zero(zero)
    );

    ula_multiciclo #(.BITS(8)) dut8 (
        .clk(clk), .rst(rst8), .inicio(inicio8), .operacao(op8),
        .dina(a8), .dinb(b8), .constante(k8), .imediato(imm8),
        .ocupado(ocupado8), .pronto(pronto8), .dout(dout8), .zero(zero8)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    typedef struct {
        logic [63:0] val;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic [63:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = {63'd0, ($signed(a) < $signed(b))};
            4'd6:    r = {63'd0, (a < b)};
            4'd7:    r = a << b[5:0];
            4'd8:    r = a >> b[5:0];
            4'd9:    r = $signed(a) >>> b[5:0];
            4'd10:   r = a * b;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [3:0] op, input logic [63:0] b);
        if (op >= 4'd7 && op <= 4'd9) return int'(b[5:0]) + 1;
        if (op == 4'd10) return 64;
        return 1;
    endfunction

    // Completion monitor: every pronto must match the oldest outstanding expectation.
    exp_t e;
    always @(negedge clk) begin
        if (!rst && pronto) begin
            check("ocupado_with_pronto", {63'd0, ocupado}, 64'd0);
            if (sb.size() == 0) begin
                check("spurious_pronto", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("dout", dout, e.val);
                check("zero", {63'd0, zero}, {63'd0, (e.val == 64'd0)});
                check("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    int n_p8 = 0;
    always @(negedge clk) if (pronto8) n_p8++;

    // Called at a negedge; holds inicio for one cycle, then scrambles the operand inputs.
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] k, input logic imm, input bit push);
        logic [63:0] bsel;
        bsel      = imm ? k : b;
        operacao  = op;
        dina      = a;
        dinb      = b;
        constante = k;
        imediato  = imm;
        inicio    = 1'b1;
        if (push) sb.push_back('{val: model(op, a, bsel), cyc: cyc + 1 + latency(op, bsel)});
        @(negedge clk);
        inicio    = 1'b0;
        dina      = ~a;
        dinb      = ~b;
        constante = ~k;
        operacao  = 4'd3;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout", 64'd1, 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_p8(input string tag);
        int n = 0;
        while (!pronto8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!pronto8) check(tag, 64'd1, 64'd0);
    endtask

    initial begin
        int p0, n;
        logic [3:0]  rop;
        logic [63:0] ra, rb;

        rst = 1'b1; inicio = 1'b0; operacao = '0; dina = '0; dinb = '0;
        constante = '0; imediato = 1'b0;
        rst8 = 1'b1; inicio8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; k8 = '0; imm8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst8 = 1'b0;

        check("rst_dout", dout, 64'd0);
        check("rst_zero", {63'd0, zero}, 64'd1);
        check("rst_ocupado", {63'd0, ocupado}, 64'd0);
        check("rst_pronto", {63'd0, pronto}, 64'd0);

        issue(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b1); wait_idle();
        issue(4'd1, 64'd5, 64'd5, 64'd9, 1'b0, 1'b1);                    wait_idle();
        issue(4'd5, '1, 64'd1, 64'd0, 1'b0, 1'b1);                       wait_idle();
        issue(4'd6, '1, 64'd1, 64'd0, 1'b0, 1'b1);                       wait_idle();
        issue(4'd2, 64'h1234, 64'hDEAD_BEEF_0000_FF00, 64'hFF, 1'b1, 1'b1); wait_idle();
        issue(4'd9, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 1'b0, 1'b1); wait_idle();
        issue(4'd7, 64'hA5A5_0000_1234_5678, 64'd0, 64'd0, 1'b0, 1'b1);  wait_idle();
        issue(4'd8, 64'hA5A5_0000_1234_5678, 64'h140, 64'd0, 1'b0, 1'b1); wait_idle();
        issue(4'd12, 64'd77, 64'd3, 64'd0, 1'b0, 1'b1);                  wait_idle();

        // MUL with a second start mid-operation that must be ignored
        issue(4'd10, 64'd12345, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        issue(4'd0, 64'd1, 64'd2, 64'd0, 1'b0, 1'b0);
        wait_idle();
        repeat (5) @(negedge clk);
        check("mul_neg_hold", dout, 64'hFFFF_FFFF_FFFF_6F55);

        // Back-to-back: ADD issued in the MUL's pronto cycle
        issue(4'd10, 64'd7, 64'd9, 64'd0, 1'b0, 1'b1);
        n = 0;
        while (!pronto && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_pronto_seen", {63'd0, pronto}, 64'd1);
        issue(4'd0, 64'd10, 64'd20, 64'd0, 1'b0, 1'b1);
        wait_idle();

        for (int i = 0; i < 12; i++) begin
            rop = 4'($urandom_range(0, 12));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if (i % 3 == 0) rb[5:0] = 6'd0;
            issue(rop, ra, rb, ~rb, 1'($urandom_range(0, 1)), 1'b1);
            wait_idle();
        end

        // 8-bit instance: reset aborts a MUL in flight
        op8 = 4'd0; a8 = 8'd3; b8 = 8'd4; inicio8 = 1'b1;
        @(negedge clk); inicio8 = 1'b0;
        wait_p8("p8_add_timeout");
        check("p8_add", {56'd0, dout8}, 64'd7);
        @(negedge clk);
        p0 = n_p8;
        op8 = 4'd10; a8 = 8'd5; b8 = 8'd6; inicio8 = 1'b1;
        @(negedge clk); inicio8 = 1'b0;
        @(negedge clk); rst8 = 1'b1;
        @(negedge clk); rst8 = 1'b0;
        check("p8_abort_dout", {56'd0, dout8}, 64'd0);
        check("p8_abort_zero", {63'd0, zero8}, 64'd1);
        check("p8_abort_ocupado", {63'd0, ocupado8}, 64'd0);
        repeat (12) @(negedge clk);
        check("p8_abort_no_pronto", 64'(n_p8), 64'(p0));

        // Reset wins over a simultaneous start
        op8 = 4'd0; a8 = 8'd1; b8 = 8'd1; rst8 = 1'b1; inicio8 = 1'b1;
        @(negedge clk); rst8 = 1'b0; inicio8 = 1'b0;
        check("p8_rst_prio_ocupado", {63'd0, ocupado8}, 64'd0);
        repeat (3) @(negedge clk);
        check("p8_rst_prio_no_pronto", 64'(n_p8), 64'(p0));

        op8 = 4'd0; a8 = 8'hFF; b8 = 8'h01; inicio8 = 1'b1;
        @(negedge clk); inicio8 = 1'b0;
        wait_p8("p8_wrap_timeout");
        check("p8_wrap_dout", {56'd0, dout8}, 64'd0);
        check("p8_wrap_zero", {63'd0, zero8}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ula_multiciclo.md
# ula_multiciclo

Parametrised multi-cycle ALU that succeeds the single-cycle add/subtract unit in the datapath. It adds logic, compare, shift and multiply operations, and keeps the same operand-B source selection (register operand or immediate constant). Single-cycle operations complete in one clock; shifts and multiply run iteratively behind a start/busy/done handshake. The block sits between the register-file read ports and the writeback mux; the control unit starts it and stalls while it is busy.

## Interface
Parameters:
- BITS, 64, datapath width; any value ≥ 4, power of two.
- SHW, $clog2(BITS), width of the shift amount (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inicio  in  1  start request; sampled on the rising edge.
- operacao  in  4  operation code; see Operation.
- dina  in  BITS  operand A.
- dinb  in  BITS  register operand B.
- constante  in  BITS  immediate operand B.
- imediato  in  1  1 selects constante as operand B, 0 selects dinb.
- ocupado  out  1  operation in progress; new starts are ignored while high.
- pronto  out  1  one-cycle pulse; dout holds a new result.
- dout  out  BITS  registered result; holds its value until the next completion.
- zero  out  1  registered flag, 1 when dout == 0.

## Operation
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLT: signed A<B gives 1, otherwise 0.
  - 6 SLTU: unsigned A<B.
  - 7 SLL.
  - 8 SRL.
  - 9 SRA.
  - 10 MUL: low BITS bits of A×B.
  - 11–15: result 0, single-cycle.
- Arithmetic is modulo 2^BITS and carry-out is discarded. SLT and SLTU return zero-extended 0 or 1.
- Shift amount is B[SHW-1:0]; upper bits of B are ignored. SRA replicates A[BITS-1].
- Operand capture: when inicio=1 and ocupado=0 at an edge, the block registers A, the selected B and operacao. Input changes after that edge have no effect until the next accepted start.
- State machine:
  - OCIOSO: on an accepted start, go to CALCULA.
  - CALCULA: iterate.
    - Single-cycle opcodes complete on the first CALCULA edge.
    - Shifts load a counter with shamt and shift 1 bit per edge, decrementing the counter. The operation completes on the edge where the counter is 0 (shamt 0 completes on the first edge, result = A).
    - MUL is shift-add: one multiplier bit per edge for BITS edges.
  - On completion, write dout and zero, pulse pronto, and return to OCIOSO.

## Timing
- Start accepted at edge k. pronto is high for exactly the cycle following edge k+L, where L is:
  - L = 1 for opcodes 0–6 and 11–15.
  - L = shamt+1 for opcodes 7–9.
  - L = BITS for opcode 10.
- ocupado rises at edge k and falls at edge k+L, so ocupado and pronto are never high together.
- inicio in the cycle where pronto is high is accepted (back-to-back): the next result arrives L cycles later.
- inicio while ocupado=1 is ignored. It is not queued, and neither the in-flight operands nor the in-flight result change.
- dout and zero change only at completion edges or on reset.
- Reset values: state OCIOSO, dout 0, zero 1, pronto 0, ocupado 0, counters 0.
- Reset mid-operation aborts the operation: no pronto is issued, and dout is cleared to 0 at the reset edge.
- Reset has priority over a simultaneous inicio; that start is dropped.

## Test plan
- Reset, then ADD 64'h7FFF_FFFF_FFFF_FFFF + 1 with imediato=0 → pronto 1 cycle later, dout 64'h8000_0000_0000_0000, zero 0. SUB 5−5 → dout 0, zero 1.
- SLT with A=−1, B=1 → dout 1. SLTU with the same operands → dout 0. AND with imediato=1, constante=64'hFF, A=64'h1234 → dout 64'h34, and dinb has no effect.
- SRA A=64'h8000_0000_0000_0000, B=63 → pronto exactly 64 cycles after start, dout all ones. SLL with shamt 0 → 1-cycle latency, dout=A. SRL with B=64'h140 (shamt 0 after masking) → dout=A.
- MUL 12345×(−3) → after 64 cycles, dout = low 64 bits of −37035. A second inicio mid-operation is ignored and produces exactly one pronto.
- Back-to-back: MUL followed by ADD issued in the pronto cycle → ADD result 1 cycle after the MUL pronto. ocupado never overlaps pronto.
- BITS=8 instance: rst asserted in cycle 3 of a MUL → no pronto, dout 0, zero 1, ocupado 0. A subsequent ADD 8'hFF+1 → dout 0, zero 1.
